// File: rtl/seg7_multi_display.sv
// N-digit 7-segment display driver: hex or sequential double-dabble decimal,
// leading-zero blanking, overflow dashes and blinking behind a valid/ready handshake.
module seg7_multi_display #(
    parameter int NUM_DIGITS = 6,
    parameter int DATA_W     = 24,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_dec,
    input  logic                    in_blank_lz,
    input  logic                    in_blink,
    output logic [7*NUM_DIGITS-1:0] seg_out,
    output logic                    overflow,
    output logic                    busy
);
    localparam int BCD_W = 4 * (NUM_DIGITS + 1);
    localparam int HEX_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int BLK_W = $clog2(BLINK_DIV);

    // Glyphs are held active-low internally; POL flips them for active-high boards.
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] POL         = ACTIVE_LOW ? 7'b0000000 : 7'b1111111;
    localparam logic [7*NUM_DIGITS-1:0] BLANK_ALL = {NUM_DIGITS{GLYPH_BLANK ^ POL}};

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_W-1:0]       data_q;
    logic [BCD_W-1:0]        bcd_q;
    logic                    sticky_q;
    logic                    dec_q, blz_q, blink_q;
    logic [7*NUM_DIGITS-1:0] disp_q, seg_q, seg_d, upd_seg;
    logic                    ovf_q, upd_ovf, hex_ovf;
    logic [BLK_W-1:0]        blk_cnt_q, blk_cnt_d;
    logic                    phase_q;
    logic [BCD_W-1:0]        bcd_adj;
    logic [HEX_W-1:0]        hex_bits;
    logic [3:0]              dig [NUM_DIGITS];
    logic                    accept;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'b1000000;
            4'h1: hex_glyph = 7'b1111001;
            4'h2: hex_glyph = 7'b0100100;
            4'h3: hex_glyph = 7'b0110000;
            4'h4: hex_glyph = 7'b0011001;
            4'h5: hex_glyph = 7'b0010010;
            4'h6: hex_glyph = 7'b0000010;
            4'h7: hex_glyph = 7'b1111000;
            4'h8: hex_glyph = 7'b0000000;
            4'h9: hex_glyph = 7'b0010000;
            4'hA: hex_glyph = 7'b0001000;
            4'hB: hex_glyph = 7'b0000011;
            4'hC: hex_glyph = 7'b1000110;
            4'hD: hex_glyph = 7'b0100001;
            4'hE: hex_glyph = 7'b0000110;
            4'hF: hex_glyph = 7'b0001110;
            default: hex_glyph = GLYPH_BLANK;
        endcase
    endfunction

    // Double-dabble correction: every BCD digit of 5 or more gets +3 before the shift.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int k = 0; k < NUM_DIGITS + 1; k++) begin
            if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign accept   = (state_q == IDLE) && in_valid;
    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign seg_out  = seg_q;
    assign overflow = ovf_q;
    assign bcd_adj  = dabble_adjust(bcd_q);

    // Next-state logic: decimal values detour through DATA_W conversion cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = in_dec ? CONVERT : UPDATE;
            CONVERT: if (cnt_q == CNT_W'(DATA_W - 1)) state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Latch attributes on accept; count conversion steps and catch bits lost off the BCD top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q    <= 1'b0;
            blz_q    <= 1'b0;
            blink_q  <= 1'b0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else if (accept) begin
            dec_q    <= in_dec;
            blz_q    <= in_blank_lz;
            blink_q  <= in_blink;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else if (state_q == CONVERT) begin
            cnt_q    <= cnt_q + 1'b1;
            sticky_q <= sticky_q | bcd_adj[BCD_W-1];
        end
    end

    // Value and BCD shift registers; only ever read after a fresh accept has loaded them.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q <= in_data;
            bcd_q  <= '0;
        end else if (state_q == CONVERT) begin
            data_q <= data_q << 1;
            bcd_q  <= {bcd_adj[BCD_W-2:0], data_q[DATA_W-1]};
        end
    end

    // Build the glyph set and overflow flag that the UPDATE edge will commit.
    always_comb begin
        logic       nz_seen;
        logic [6:0] g;
        hex_bits = '0;
        hex_ovf  = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < HEX_W) hex_bits[i % HEX_W] = data_q[i];
            else           hex_ovf = hex_ovf | data_q[i];
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            dig[k] = dec_q ? bcd_q[4*k +: 4] : hex_bits[4*k +: 4];
        end
        upd_ovf = dec_q ? ((bcd_q[BCD_W-1 -: 4] != 4'd0) || sticky_q) : hex_ovf;
        upd_seg = '0;
        nz_seen = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (dig[k] != 4'd0) nz_seen = 1'b1;
            if (upd_ovf)                         g = GLYPH_DASH;
            else if (blz_q && !nz_seen && k != 0) g = GLYPH_BLANK;
            else                                 g = hex_glyph(dig[k]);
            upd_seg[7*k +: 7] = g ^ POL;
        end
    end

    // Blink gating sits in front of the output register, so it lags the phase by one cycle.
    always_comb begin
        seg_d = (state_q == UPDATE) ? upd_seg : disp_q;
        if (blink_q && phase_q) seg_d = BLANK_ALL;
    end

    // Display registers: committed glyphs, gated output and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= BLANK_ALL;
            seg_q  <= BLANK_ALL;
            ovf_q  <= 1'b0;
        end else begin
            seg_q <= seg_d;
            if (state_q == UPDATE) begin
                disp_q <= upd_seg;
                ovf_q  <= upd_ovf;
            end
        end
    end

    assign blk_cnt_d = (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) ? '0 : blk_cnt_q + 1'b1;

    // Free-running blink timebase; phase flips each time the counter wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q <= '0;
            phase_q   <= 1'b0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
            if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) phase_q <= ~phase_q;
        end
    end

endmodule
